// File: rtl/spi_master_sequencer_if.sv
// Handshake and shift-stage control bundle between the system controller,
// the SPI transaction sequencer and the sender/receiver shift stages.
interface spi_master_sequencer_if;
  logic       START;
  logic       ABORT;
  logic [7:0] TX_DATA;
  logic [7:0] RX_BUS;
  logic [7:0] TX_BUS;
  logic       SCLK;
  logic       CS_N;
  logic       SR_CLR;
  logic       WRITE;
  logic       TE;
  logic       RE;
  logic       READ;
  logic [7:0] RX_DATA;
  logic       BUSY;
  logic       DONE;

  modport master (
    input  START, ABORT, TX_DATA, RX_BUS,
    output TX_BUS, SCLK, CS_N, SR_CLR, WRITE, TE, RE, READ, RX_DATA, BUSY, DONE
  );

  modport slave (
    output START, ABORT, TX_DATA, RX_BUS,
    input  TX_BUS, SCLK, CS_N, SR_CLR, WRITE, TE, RE, READ, RX_DATA, BUSY, DONE
  );
endinterface

// File: rtl/spi_master_sequencer.sv
// One-byte SPI transaction sequencer: drives SCLK, chip select and the
// clear/load/enable/read strobes for the sender and receiver shift stages.
module spi_master_sequencer #(
  parameter int unsigned CLK_DIV = 4
) (
  input logic                    CLK,
  input logic                    CLR_N,
  spi_master_sequencer_if.master bus
);
  localparam int unsigned DIV_W  = 8;
  localparam int unsigned BIT_W  = 4;
  localparam int unsigned DATA_W = 8;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(7);

  typedef enum logic [2:0] {IDLE, CLEAR, LOAD, XFER, CAPTURE, FINISH} state_e;

  state_e              state_q, state_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic                cap_q, cap_d;
  logic                sclk_q, sclk_d;
  logic [DATA_W-1:0]   tx_bus_q, tx_bus_d;
  logic [DATA_W-1:0]   rx_data_q, rx_data_d;
  logic                cs_n_q, cs_n_d;
  logic                sr_clr_q, sr_clr_d;
  logic                write_q, write_d;
  logic                te_q, te_d;
  logic                re_q, re_d;
  logic                read_q, read_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                tick_c, fall_c, abort_c;

  // Next state, counters and registered strobes derived from the next state
  always_comb begin
    state_d   = state_q;
    div_d     = '0;
    bit_d     = '0;
    cap_d     = 1'b0;
    sclk_d    = 1'b0;
    tx_bus_d  = tx_bus_q;
    rx_data_d = rx_data_q;
    tick_c    = (div_q == DIV_LAST);
    fall_c    = tick_c && sclk_q;
    abort_c   = bus.ABORT && (state_q != IDLE);

    unique case (state_q)
      IDLE: begin
        if (bus.START) begin
          state_d  = CLEAR;
          tx_bus_d = bus.TX_DATA;
        end
      end
      CLEAR:   state_d = LOAD;
      LOAD:    if (fall_c) state_d = XFER;
      XFER:    if (fall_c && (bit_q == BIT_LAST)) state_d = CAPTURE;
      CAPTURE: begin
        if (cap_q) begin
          state_d   = FINISH;
          rx_data_d = bus.RX_BUS;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (abort_c) begin
      state_d   = IDLE;
      rx_data_d = rx_data_q;
    end

    // Bit counter counts SCLK falling toggles only while shifting
    if (state_q == XFER) begin
      bit_d = fall_c ? BIT_W'(bit_q + BIT_W'(1)) : bit_q;
    end

    // Divider and SCLK restart from zero/low on every state entry
    if ((state_d == state_q) && ((state_d == LOAD) || (state_d == XFER))) begin
      div_d  = tick_c ? '0 : DIV_W'(div_q + DIV_W'(1));
      sclk_d = tick_c ? ~sclk_q : sclk_q;
    end

    cap_d    = (state_q == CAPTURE) && (state_d == CAPTURE);
    cs_n_d   = !(state_d inside {LOAD, XFER, CAPTURE});
    sr_clr_d = (state_d == CLEAR) || abort_c;
    write_d  = (state_d == LOAD);
    te_d     = (state_d == LOAD) || (state_d == XFER);
    re_d     = (state_d == XFER);
    read_d   = (state_d == CAPTURE);
    busy_d   = (state_d != IDLE);
    done_d   = (state_d == FINISH);
  end

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      state_q   <= IDLE;
      div_q     <= '0;
      bit_q     <= '0;
      cap_q     <= 1'b0;
      sclk_q    <= 1'b0;
      tx_bus_q  <= '0;
      rx_data_q <= '0;
      cs_n_q    <= 1'b1;
      sr_clr_q  <= 1'b0;
      write_q   <= 1'b0;
      te_q      <= 1'b0;
      re_q      <= 1'b0;
      read_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      cap_q     <= cap_d;
      sclk_q    <= sclk_d;
      tx_bus_q  <= tx_bus_d;
      rx_data_q <= rx_data_d;
      cs_n_q    <= cs_n_d;
      sr_clr_q  <= sr_clr_d;
      write_q   <= write_d;
      te_q      <= te_d;
      re_q      <= re_d;
      read_q    <= read_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.TX_BUS  = tx_bus_q;
  assign bus.SCLK    = sclk_q;
  assign bus.CS_N    = cs_n_q;
  assign bus.SR_CLR  = sr_clr_q;
  assign bus.WRITE   = write_q;
  assign bus.TE      = te_q;
  assign bus.RE      = re_q;
  assign bus.READ    = read_q;
  assign bus.RX_DATA = rx_data_q;
  assign bus.BUSY    = busy_q;
  assign bus.DONE    = done_q;
endmodule

// File: tb/tb_spi_master_sequencer.sv
// Drives a CLK_DIV=4 and a CLK_DIV=1 sequencer from shared stimulus and checks
// both against a cycle-offset timeline model plus a DONE scoreboard.
module tb_spi_master_sequencer;
  logic       CLK   = 1'b0;
  logic       CLR_N = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] tx    = 8'h00;
  logic [7:0] rxb   = 8'h00;

  spi_master_sequencer_if if4 ();
  spi_master_sequencer_if if1 ();

  assign if4.START = start;  assign if1.START = start;
  assign if4.ABORT = abort;  assign if1.ABORT = abort;
  assign if4.TX_DATA = tx;   assign if1.TX_DATA = tx;
  assign if4.RX_BUS = rxb;   assign if1.RX_BUS = rxb;

  spi_master_sequencer #(.CLK_DIV(4)) u_dut4 (.CLK(CLK), .CLR_N(CLR_N), .bus(if4.master));
  spi_master_sequencer #(.CLK_DIV(1)) u_dut1 (.CLK(CLK), .CLR_N(CLR_N), .bus(if1.master));

  always #5 CLK = ~CLK;

  // {CS_N, SCLK, SR_CLR, WRITE, TE, RE, READ, BUSY, DONE}
  logic [8:0] ctl4, ctl1;
  assign ctl4 = {if4.CS_N, if4.SCLK, if4.SR_CLR, if4.WRITE, if4.TE, if4.RE, if4.READ, if4.BUSY, if4.DONE};
  assign ctl1 = {if1.CS_N, if1.SCLK, if1.SR_CLR, if1.WRITE, if1.TE, if1.RE, if1.READ, if1.BUSY, if1.DONE};

  typedef struct packed {
    logic [7:0]  tx;
    logic [31:0] acc;
  } sb_t;

  sb_t         q4[$];
  sb_t         q1[$];
  int          m_k[2]  = '{0, 0};
  bit          m_ab[2] = '{1'b0, 1'b0};
  logic [7:0]  e_tx[2] = '{8'h00, 8'h00};
  logic [7:0]  e_rx[2] = '{8'h00, 8'h00};
  int unsigned cyc     = 0;
  int          n_tests = 0;
  int          n_fail  = 0;

  function automatic int dv(int i);
    return (i == 0) ? 4 : 1;
  endfunction

  // Expected control vector k cycles after START was accepted (k=0: idle)
  function automatic logic [8:0] exp_ctl(int k, bit ab, int d);
    if (ab)              return 9'b1_0_1_0_0_0_0_0_0;
    if (k == 0)          return 9'b1_0_0_0_0_0_0_0_0;
    if (k == 1)          return 9'b1_0_1_0_0_0_0_1_0;
    if (k <= 2*d + 1)    return {1'b0, 1'(((k - 2) / d) % 2), 7'b0_1_1_0_0_1_0};
    if (k <= 18*d + 1)   return {1'b0, 1'(((k - 2*d - 2) / d) % 2), 7'b0_0_1_1_0_1_0};
    if (k <= 18*d + 3)   return 9'b0_0_0_0_0_0_1_1_0;
    return 9'b1_0_0_0_0_0_0_1_1;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: advances the transaction timeline on each rising edge
  initial begin : model
    forever begin
      @(posedge CLK);
      cyc++;
      for (int i = 0; i < 2; i++) begin
        int d;
        int last;
        d    = dv(i);
        last = 18*d + 4;
        if (!CLR_N) begin
          m_k[i] = 0; m_ab[i] = 1'b0; e_tx[i] = 8'h00; e_rx[i] = 8'h00;
          if (i == 0) q4.delete(); else q1.delete();
        end else if (m_k[i] == 0) begin
          m_ab[i] = 1'b0;
          if (start) begin
            m_k[i]  = 1;
            e_tx[i] = tx;
            if (i == 0) q4.push_back(sb_t'{tx, 32'(cyc)});
            else        q1.push_back(sb_t'{tx, 32'(cyc)});
          end
        end else if (abort) begin
          if (m_k[i] != last) begin
            if (i == 0) void'(q4.pop_back()); else void'(q1.pop_back());
          end
          m_k[i]  = 0;
          m_ab[i] = 1'b1;
        end else begin
          if (m_k[i] == 18*d + 3) e_rx[i] = rxb;
          m_k[i] = (m_k[i] == last) ? 0 : m_k[i] + 1;
        end
      end
    end
  end

  // Monitor: per-cycle comparison plus scoreboard pop on every DONE
  initial begin : monitor
    forever begin
      @(negedge CLK);
      for (int i = 0; i < 2; i++) begin
        logic [8:0] act, exp;
        logic [7:0] atx, arx, etx, erx;
        sb_t        rec;
        act = (i == 0) ? ctl4 : ctl1;
        atx = (i == 0) ? if4.TX_BUS : if1.TX_BUS;
        arx = (i == 0) ? if4.RX_DATA : if1.RX_DATA;
        if (!CLR_N) begin
          exp = 9'b1_0000_0000; etx = 8'h00; erx = 8'h00;
        end else begin
          exp = exp_ctl(m_k[i], m_ab[i], dv(i)); etx = e_tx[i]; erx = e_rx[i];
        end
        chk($sformatf("div%0d_ctl", dv(i)), 32'(act), 32'(exp));
        chk($sformatf("div%0d_tx_bus", dv(i)), 32'(atx), 32'(etx));
        chk($sformatf("div%0d_rx_data", dv(i)), 32'(arx), 32'(erx));
        if (act[0]) begin
          if ((i == 0 && q4.size() == 0) || (i == 1 && q1.size() == 0)) begin
            n_tests++;
            n_fail++;
            $display("FAIL div%0d_unexpected_done: got DONE=1 expected no pending transfer", dv(i));
          end else begin
            rec = (i == 0) ? q4.pop_front() : q1.pop_front();
            chk($sformatf("div%0d_done_latency", dv(i)), 32'(cyc - rec.acc + 1), 32'(18*dv(i) + 4));
            chk($sformatf("div%0d_done_tx_bus", dv(i)), 32'(atx), 32'(rec.tx));
          end
        end
      end
    end
  end

  task automatic step(int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic pulse_start(logic [7:0] d);
    tx = d; start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((m_k[0] != 0 || m_k[1] != 0) && n < 2000) begin
      step(1);
      n++;
    end
    if (n >= 2000) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_idle_timeout: got busy after %0d cycles expected idle", n);
    end
    step(2);
  endtask

  initial begin : stim
    #1 CLR_N = 1'b0;
    step(3);
    CLR_N = 1'b1;
    step(20);

    // Nominal transfer
    rxb = 8'h3C;
    pulse_start(8'hA5);
    wait_idle();

    // START held high: back-to-back transfers with one idle cycle between
    tx = 8'h01; start = 1'b1;
    step(1);
    tx = 8'h02;
    step(77);
    start = 1'b0;
    wait_idle();

    // START while busy is ignored
    rxb = 8'h81;
    pulse_start(8'h5A);
    step(39);
    pulse_start(8'hFF);
    wait_idle();

    // ABORT after three SCLK periods of shifting, then a normal transfer
    rxb = 8'h17;
    pulse_start(8'hC3);
    step(32);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    step(3);
    rxb = 8'h5E;
    pulse_start(8'h96);
    wait_idle();

    // Randomized transfers with occasional aborts and stray STARTs
    for (int t = 0; t < 8; t++) begin
      rxb = 8'($urandom);
      pulse_start(8'($urandom));
      if ($urandom_range(0, 2) == 0) begin
        step(int'($urandom_range(1, 80)));
        abort = 1'b1;
        step(1);
        abort = 1'b0;
      end
      if ($urandom_range(0, 1) == 1) begin
        step(int'($urandom_range(1, 60)));
        pulse_start(8'($urandom));
      end
      wait_idle();
      step(int'($urandom_range(0, 3)));
    end

    // Asynchronous reset between edges while loading
    rxb = 8'hE4;
    pulse_start(8'h7E);
    step(3);
    @(posedge CLK);
    #2 CLR_N = 1'b0;
    #1;
    chk("async_rst_ctl4", 32'(ctl4), 32'(9'b1_0000_0000));
    chk("async_rst_ctl1", 32'(ctl1), 32'(9'b1_0000_0000));
    chk("async_rst_tx4", 32'(if4.TX_BUS), 32'(8'h00));
    chk("async_rst_rx4", 32'(if4.RX_DATA), 32'(8'h00));
    chk("async_rst_rx1", 32'(if1.RX_DATA), 32'(8'h00));
    step(2);
    CLR_N = 1'b1;
    step(5);

    rxb = 8'hB2;
    pulse_start(8'h4B);
    wait_idle();

    chk("sb_empty_div4", 32'(q4.size()), 32'd0);
    chk("sb_empty_div1", 32'(q1.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
